instr_mem_loader: RTL



---
 rtl/instr_mem_loader_pkg.sv | 23 ++
 rtl/loader_word_assembler.sv | 44 ++++
 rtl/instr_mem_loader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared constants and state encoding for the boot-time instruction loader.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CHECK state).
package instr_mem_loader_pkg;

    localparam int unsigned IMEM_DEPTH_WORDS = 64;
    localparam logic [31:0] IMEM_BASE_ADDR   = 32'h0000_0000;
    localparam int unsigned WORD_BYTES       = 4;
    localparam int unsigned HDR_BYTES        = 2;
    localparam int unsigned LDR_CNT_W        = 16;

    typedef enum logic [2:0] {
        ST_LEN_LO,
        ST_LEN_HI,
        ST_BYTE,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
`ifdef LOADER_CHECKSUM_EN
        , ST_CHECK
`endif
    } state_e;

endpackage

// File: rtl/loader_word_assembler.sv
// Little-endian byte-to-word assembler for the instruction loader.
// Flags word completion combinationally on the transfer of the last lane.
module loader_word_assembler
    import instr_mem_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear_i,
    input  logic                    byte_xfer_i,
    input  logic [7:0]              byte_i,
    output logic [8*WORD_BYTES-1:0] word_o,
    output logic                    word_done_o
);

    localparam int unsigned LANE_W = $clog2(WORD_BYTES);

    logic [LANE_W-1:0]       lane_q, lane_d;
    logic [8*WORD_BYTES-1:0] word_q, word_d;

    always_comb begin
        lane_d = lane_q;
        word_d = word_q;
        if (clear_i) begin
            lane_d = '0;
        end else if (byte_xfer_i) begin
            word_d[8*lane_q +: 8] = byte_i;
            lane_d = lane_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q <= '0;
            word_q <= '0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
        end
    end

    assign word_o      = word_q;
    assign word_done_o = byte_xfer_i && (lane_q == LANE_W'(WORD_BYTES - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: streams a length-prefixed image into instruction memory
// and holds the core in reset until it is complete (LOADER_CHECKSUM_EN optional).
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = IMEM_DEPTH_WORDS,
    parameter logic [31:0] BASE_ADDR   = IMEM_BASE_ADDR,
    parameter int unsigned CNT_W       = LDR_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    input  logic             reload,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wd,
    output logic             core_reset,
    output logic             load_done,
    output logic             load_error,
    output logic [CNT_W-1:0] words_loaded
);

`ifdef LOADER_CHECKSUM_EN
    localparam state_e ST_TAIL = ST_CHECK;
`else
    localparam state_e ST_TAIL = ST_DONE;
`endif

    state_e                   state_q, state_d;
    logic [8*HDR_BYTES-1:0]   n_q, n_d;
    logic [8*HDR_BYTES-1:0]   hdr_n;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     xfer;
    logic                     word_done;
    logic [8*WORD_BYTES-1:0]  asm_word;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    assign in_ready = state_q inside {ST_LEN_LO, ST_LEN_HI, ST_BYTE, ST_CHECK};
`else
    assign in_ready = state_q inside {ST_LEN_LO, ST_LEN_HI, ST_BYTE};
`endif

    assign xfer  = in_valid && in_ready;
    assign hdr_n = {in_data, n_q[7:0]};

    loader_word_assembler u_asm (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (state_q != ST_BYTE),
        .byte_xfer_i (xfer && (state_q == ST_BYTE)),
        .byte_i      (in_data),
        .word_o      (asm_word),
        .word_done_o (word_done)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        imem_we = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            ST_LEN_LO: begin
                if (in_valid) begin
                    n_d[7:0] = in_data;
                    state_d  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (in_valid) begin
                    n_d   = hdr_n;
                    cnt_d = '0;
                    if (hdr_n == '0)
                        state_d = ST_TAIL;
                    else if (32'(hdr_n) > DEPTH_WORDS)
                        state_d = ST_ERROR;
                    else
                        state_d = ST_BYTE;
                end
            end
            ST_BYTE: begin
                if (word_done)
                    state_d = ST_WRITE;
            end
            ST_WRITE: begin
                imem_we = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (32'(cnt_q) + 32'd1 == 32'(n_q))
                    state_d = ST_TAIL;
                else
                    state_d = ST_BYTE;
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (in_valid)
                    state_d = (in_data == csum_q) ? ST_DONE : ST_ERROR;
            end
`endif
            ST_DONE, ST_ERROR: begin
                if (reload) begin
                    state_d = ST_LEN_LO;
                    cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            default: state_d = ST_LEN_LO;
        endcase
`ifdef LOADER_CHECKSUM_EN
        // Running XOR covers header and payload, never the checksum byte itself
        if (xfer && (state_q != ST_CHECK))
            csum_d = csum_q ^ in_data;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LEN_LO;
            n_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset)
            csum_q <= '0;
        else
            csum_q <= csum_d;
    end
`endif

    assign imem_addr    = BASE_ADDR + (32'(cnt_q) << 2);
    assign imem_wd      = asm_word;
    assign load_done    = (state_q == ST_DONE);
    assign load_error   = (state_q == ST_ERROR);
    assign core_reset   = (state_q != ST_DONE);
    assign words_loaded = cnt_q;

endmodule
